ni_tx_arbiter: RTL and testbench

NI_TX_ARBITER -- requirements
Module: ni_tx_arbiter

---
 rtl/ni_tx_arbiter.sv | 116 +++++++++++
 tb/tb_ni_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tx_arbiter.sv
// rtl/ni_tx_arbiter.sv - round-robin wormhole arbiter feeding one async-FIFO write port
// A requester keeps the port from grant until its tail flit is written; flits past MAX_FLITS raise a sticky error.
module ni_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_FLITS = 16
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W:0]           wdata,
  output logic                      winc,
  input  logic                      wfull,
  output logic [N_REQ-1:0]          grant,
  output logic [15:0]               pkt_cnt,
  output logic                      err_overlen
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = ($clog2(MAX_FLITS) + 1 > 4) ? $clog2(MAX_FLITS) + 1 : 4;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [CNT_W-1:0]   flit_cnt_q;
  logic [15:0]        pkt_cnt_q;
  logic               err_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_oh;
  logic               in_xfer;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;

  // Search starts at rr_ptr and wraps, so the requester after the last owner goes first.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    win_oh    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && req_valid[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
    if (win_found) win_oh[win_idx] = 1'b1;
  end

  assign in_xfer  = (state_q == XFER);
  assign g_valid  = req_valid[gidx_q];
  assign g_last   = req_last[gidx_q];
  assign g_data   = req_data[int'(gidx_q) * DATA_W +: DATA_W];
  assign rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  assign winc  = in_xfer & g_valid & ~wfull;
  assign wdata = in_xfer ? {g_last, g_data} : '0;

  always_comb begin
    req_ready = '0;
    if (in_xfer) req_ready[gidx_q] = ~wfull;
  end

  assign grant       = grant_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_overlen = err_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= XFER;
            gidx_q  <= win_idx;
            grant_q <= win_oh;
          end
        end
        XFER: begin
          if (winc) begin
            if (g_last) begin
              state_q    <= IDLE;
              grant_q    <= '0;
              rr_ptr_q   <= rr_ptr_d;
              flit_cnt_q <= '0;
              pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            end else begin
              // The packet keeps flowing after overlength; only the flag records it.
              if (flit_cnt_q == CNT_W'(MAX_FLITS - 1)) err_q <= 1'b1;
              flit_cnt_q <= flit_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ni_tx_arbiter.sv
// tb/tb_ni_tx_arbiter.sv - directed and randomized bench for ni_tx_arbiter against a packet-queue model
module tb_ni_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MF = 16;
  localparam int QD = 4096;

  logic            wclk = 1'b0;
  logic            wrst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [DW:0]     wdata;
  logic            winc;
  logic            wfull;
  logic [N-1:0]    grant;
  logic [15:0]     pkt_cnt;
  logic            err_overlen;

  ni_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_FLITS(MF)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wdata(wdata), .winc(winc),
    .wfull(wfull), .grant(grant), .pkt_cnt(pkt_cnt), .err_overlen(err_overlen)
  );

  always #5 wclk = ~wclk;

  logic [DW:0] fq [N][QD];
  int          hd [N];
  int          tl [N];
  logic [N-1:0] stall;
  logic        full_drv;
  int          owner, rr_m, flits_m, pkts_m;
  logic        err_m;
  logic [DW:0] wlog[$];
  int          wcyc[$];
  int          glog[$];
  int          tcount, act_cnt, rise;
  int          n_chk, n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_flit(input int r, input logic last, input logic [DW-1:0] d);
    fq[r][tl[r]] = {last, d};
    tl[r]++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    stall = '0; full_drv = 1'b0;
    owner = -1; rr_m = 0; flits_m = 0; pkts_m = 0; err_m = 1'b0;
    wlog.delete(); wcyc.delete(); glog.delete();
    act_cnt = 0; rise = -1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        req_valid[i]          = !stall[i];
        req_last[i]           = fq[i][hd[i]][DW];
        req_data[i*DW +: DW]  = fq[i][hd[i]][DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
    wfull = full_drv;
  endtask

  // One clock: drive, check outputs at the falling edge, then advance the packet model at the rising edge.
  task automatic tick();
    logic [N-1:0] eg, er;
    logic [DW:0]  ew;
    logic         ewinc, last;
    drive();
    #4;
    eg = '0; er = '0; ew = '0; ewinc = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      er[owner] = !full_drv;
      ewinc     = req_valid[owner] && !full_drv;
      ew        = {req_last[owner], req_data[owner*DW +: DW]};
    end
    check("grant", 64'(grant), 64'(eg));
    check("winc", 64'(winc), 64'(ewinc));
    check("req_ready", 64'(req_ready), 64'(er));
    check("wdata", 64'(wdata), 64'(ew));
    check("pkt_cnt", 64'(pkt_cnt), 64'(16'(pkts_m)));
    check("err_overlen", 64'(err_overlen), 64'(err_m));
    if (err_overlen && rise < 0) rise = wlog.size();
    if (winc || (|req_ready)) act_cnt++;
    if (winc) begin wlog.push_back(wdata); wcyc.push_back(tcount); end
    @(posedge wclk);
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (owner < 0 && req_valid[j]) begin owner = j; glog.push_back(j); end
      end
    end else if (ewinc) begin
      last = fq[owner][hd[owner]][DW];
      hd[owner]++;
      if (last) begin
        pkts_m++; rr_m = (owner + 1) % N; owner = -1; flits_m = 0;
      end else begin
        if (flits_m == MF - 1) err_m = 1'b1;
        flits_m++;
      end
    end
    tcount++;
    #1;
  endtask

  task automatic drain(input int max);
    int c;
    c = 0;
    while ((pending() || owner >= 0) && c < max) begin tick(); c++; end
    check("drain_done", 64'(c < max), 64'd1);
  endtask

  task automatic tick_until_hd(input int r, input int n, input int max);
    int c;
    c = 0;
    while (hd[r] < n && c < max) begin tick(); c++; end
    check("wait_flits", 64'(c < max), 64'd1);
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    clear_all();
    drive();
    #2;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_winc", 64'(winc), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err", 64'(err_overlen), 64'd0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    int exp_rr[5];
    int npk, len;
    n_chk = 0; n_pass = 0; tcount = 0;
    req_valid = '0; req_data = '0; req_last = '0; wfull = 1'b0;

    // Single 3-flit packet from requester 1
    do_reset();
    push_flit(1, 1'b0, 32'h0000BBBB);
    push_flit(1, 1'b0, 32'h00010001);
    push_flit(1, 1'b1, 32'h0100CCCC);
    tick();
    check("single_grant", 64'(grant), 64'(4'b0010));
    drain(50);
    check("single_nwr", 64'(wlog.size()), 64'd3);
    check("single_first", 64'(wlog[0]), 64'({1'b0, 32'h0000BBBB}));
    check("single_tail", 64'(wlog[2][DW]), 64'd1);
    check("single_consec", 64'(wcyc[2] - wcyc[0]), 64'd2);
    check("single_pkt", 64'(pkt_cnt), 64'd1);
    check("single_gnt0", 64'(grant), 64'd0);

    // Round robin across four continuous single-flit requesters
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) push_flit(i, 1'b1, 32'(rep * 16 + i));
    drain(100);
    exp_rr = '{0, 1, 2, 3, 0};
    check("rr_nglog", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 5; k++) check("rr_order", 64'(glog[k]), 64'(exp_rr[k]));
    for (int k = 0; k < 4; k++) check("rr_spacing", 64'(wcyc[k+1] - wcyc[k]), 64'd2);

    // Wormhole hold while requester 0 asks mid-packet
    do_reset();
    for (int k = 0; k < 4; k++) push_flit(2, k == 3, 32'hA000 + 32'(k));
    tick_until_hd(2, 1, 20);
    push_flit(0, 1'b1, 32'h5555);
    tick();
    check("worm_hold", 64'(grant), 64'(4'b0100));
    drain(50);
    check("worm_nglog", 64'(glog.size()), 64'd2);
    check("worm_first", 64'(glog[0]), 64'd2);
    check("worm_second", 64'(glog[1]), 64'd0);

    // Backpressure for five cycles mid-packet
    do_reset();
    for (int k = 0; k < 6; k++) push_flit(1, k == 5, 32'h1000 + 32'(k));
    tick_until_hd(1, 2, 20);
    full_drv = 1'b1;
    act_cnt = 0;
    repeat (5) tick();
    check("bp_quiet", 64'(act_cnt), 64'd0);
    full_drv = 1'b0;
    drain(50);
    check("bp_nwr", 64'(wlog.size()), 64'd6);
    for (int k = 0; k < 6; k++) check("bp_order", 64'(wlog[k]), 64'({k == 5, 32'h1000 + 32'(k)}));

    // Overlength: 17 flits from requester 0
    do_reset();
    for (int k = 0; k < 17; k++) push_flit(0, k == 16, 32'hF00 + 32'(k));
    drain(80);
    tick();
    check("ovl_rise", 64'(rise), 64'd16);
    check("ovl_sticky", 64'(err_overlen), 64'd1);
    check("ovl_pkt", 64'(pkt_cnt), 64'd1);
    check("ovl_nwr", 64'(wlog.size()), 64'd17);

    // Asynchronous reset during flit 2 of 4
    do_reset();
    push_flit(1, 1'b1, 32'h77);
    drain(20);
    for (int k = 0; k < 4; k++) push_flit(3, k == 3, 32'hD000 + 32'(k));
    tick_until_hd(3, 1, 20);
    drive();
    #1 wrst = 1'b1;
    #1;
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_winc", 64'(winc), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_wdata", 64'(wdata), 64'd0);
    check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
    check("mid_rst_err", 64'(err_overlen), 64'd0);
    #1 wrst = 1'b0;
    clear_all();
    drive();
    @(posedge wclk);
    #1;
    push_flit(0, 1'b1, 32'h11);
    push_flit(3, 1'b1, 32'h33);
    drain(30);
    check("post_rst_nglog", 64'(glog.size()), 64'd2);
    check("post_rst_first", 64'(glog[0]), 64'd0);
    check("post_rst_nwr", 64'(wlog.size()), 64'd2);
    check("post_rst_pkt", 64'(pkt_cnt), 64'd2);

    // Randomized traffic with stalls, backpressure and occasional overlength packets
    do_reset();
    npk = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (tl[i] - hd[i] < 6 && $urandom_range(0, 3) == 0) begin
          len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(17, 19)) : int'($urandom_range(1, 5));
          for (int k = 0; k < len; k++) push_flit(i, k == len - 1, $urandom);
          npk++;
        end
        stall[i] = ($urandom_range(0, 3) == 0);
      end
      full_drv = ($urandom_range(0, 4) == 0);
      tick();
    end
    stall = '0;
    full_drv = 1'b0;
    drain(2000);
    check("rand_pkt_total", 64'(pkt_cnt), 64'(16'(npk)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
